// File: rtl/sram_axi_bridge.sv
// Arbitrates the inst (read-only) and data SRAM-like ports onto one AXI master, data wins, one transaction in flight.
// Latency: accept N, AR/AW+W N+1, data_ok N+2 at best; addr_ok is held low outside IDLE, so requesters stall until the bus frees.
module sram_axi_bridge #(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              inst_sram_req,
    input  logic [ADDR_W-1:0] inst_sram_addr,
    output logic              inst_sram_addr_ok,
    output logic              inst_sram_data_ok,
    output logic [31:0]       inst_sram_rdata,
    input  logic              data_sram_req,
    input  logic              data_sram_wr,
    input  logic [1:0]        data_sram_size,
    input  logic [3:0]        data_sram_wstrb,
    input  logic [ADDR_W-1:0] data_sram_addr,
    input  logic [31:0]       data_sram_wdata,
    output logic              data_sram_addr_ok,
    output logic              data_sram_data_ok,
    output logic [31:0]       data_sram_rdata,
    output logic [ADDR_W-1:0] araddr,
    output logic [2:0]        arsize,
    output logic              arvalid,
    input  logic              arready,
    input  logic [31:0]       rdata,
    input  logic              rvalid,
    output logic              rready,
    output logic [ADDR_W-1:0] awaddr,
    output logic [2:0]        awsize,
    output logic              awvalid,
    input  logic              awready,
    output logic [31:0]       wdata,
    output logic [3:0]        wstrb,
    output logic              wvalid,
    input  logic              wready,
    input  logic              bvalid,
    output logic              bready
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD_ADDR,
        S_RD_DATA,
        S_WR_REQ,
        S_WR_RESP
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic [ADDR_W-1:0] r_addr;
    logic [1:0]        r_size;
    logic [3:0]        r_wstrb;
    logic [31:0]       r_wdata;
    logic              r_owner_data;
    logic              r_aw_done;
    logic              r_w_done;
    logic [31:0]       r_inst_rdata;
    logic [31:0]       r_data_rdata;

    logic w_idle;
    logic w_rd_fin;
    logic w_wr_fin;
    logic w_aw_fire;
    logic w_w_fire;

    // Handshake outputs are masked while reset is held so an aborted transfer never reports completion.
    assign w_idle   = (r_state == S_IDLE) && !reset;
    assign w_rd_fin = (r_state == S_RD_DATA) && rvalid && !reset;
    assign w_wr_fin = (r_state == S_WR_RESP) && bvalid && !reset;

    assign data_sram_addr_ok = w_idle && data_sram_req;
    assign inst_sram_addr_ok = w_idle && !data_sram_req && inst_sram_req;
    assign inst_sram_data_ok = w_rd_fin && !r_owner_data;
    assign data_sram_data_ok = (w_rd_fin && r_owner_data) || w_wr_fin;
    assign inst_sram_rdata   = inst_sram_data_ok ? rdata : r_inst_rdata;
    assign data_sram_rdata   = (w_rd_fin && r_owner_data) ? rdata : r_data_rdata;

    assign araddr  = r_addr;
    assign arsize  = {1'b0, r_size};
    assign awaddr  = r_addr;
    assign awsize  = {1'b0, r_size};
    assign wdata   = r_wdata;
    assign wstrb   = r_wstrb;
    assign arvalid = (r_state == S_RD_ADDR);
    assign rready  = (r_state == S_RD_DATA);
    assign awvalid = (r_state == S_WR_REQ) && !r_aw_done;
    assign wvalid  = (r_state == S_WR_REQ) && !r_w_done;
    assign bready  = (r_state == S_WR_RESP);

    assign w_aw_fire = awvalid && awready;
    assign w_w_fire  = wvalid && wready;

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (data_sram_addr_ok) begin
                    w_next = data_sram_wr ? S_WR_REQ : S_RD_ADDR;
                end else if (inst_sram_addr_ok) begin
                    w_next = S_RD_ADDR;
                end
            end
            S_RD_ADDR: begin
                if (arready) begin
                    w_next = S_RD_DATA;
                end
            end
            S_RD_DATA: begin
                if (rvalid) begin
                    w_next = S_IDLE;
                end
            end
            S_WR_REQ: begin
                if ((r_aw_done || w_aw_fire) && (r_w_done || w_w_fire)) begin
                    w_next = S_WR_RESP;
                end
            end
            S_WR_RESP: begin
                if (bvalid) begin
                    w_next = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_addr       <= '0;
            r_size       <= '0;
            r_wstrb      <= '0;
            r_wdata      <= '0;
            r_owner_data <= 1'b0;
            r_aw_done    <= 1'b0;
            r_w_done     <= 1'b0;
            r_inst_rdata <= '0;
            r_data_rdata <= '0;
        end else begin
            r_state <= w_next;
            // Request fields are captured only on acceptance, keeping AXI payloads stable until handshake.
            if (data_sram_addr_ok) begin
                r_addr       <= data_sram_addr;
                r_size       <= data_sram_size;
                r_wstrb      <= data_sram_wstrb;
                r_wdata      <= data_sram_wdata;
                r_owner_data <= 1'b1;
            end else if (inst_sram_addr_ok) begin
                r_addr       <= inst_sram_addr;
                r_size       <= 2'd2;
                r_wstrb      <= '0;
                r_wdata      <= '0;
                r_owner_data <= 1'b0;
            end
            if (r_state != S_WR_REQ) begin
                r_aw_done <= 1'b0;
                r_w_done  <= 1'b0;
            end else begin
                if (w_aw_fire) r_aw_done <= 1'b1;
                if (w_w_fire)  r_w_done  <= 1'b1;
            end
            if (inst_sram_data_ok) begin
                r_inst_rdata <= rdata;
            end
            if (w_rd_fin && r_owner_data) begin
                r_data_rdata <= rdata;
            end
        end
    end

endmodule

// File: tb/tb_sram_axi_bridge.sv
// Directed scenarios plus a randomized run against a word-memory reference model.
module tb_sram_axi_bridge;
    localparam int ADDR_W = 32;

    logic              clk = 1'b0;
    logic              reset;
    logic              inst_sram_req;
    logic [ADDR_W-1:0] inst_sram_addr;
    logic              inst_sram_addr_ok, inst_sram_data_ok;
    logic [31:0]       inst_sram_rdata;
    logic              data_sram_req, data_sram_wr;
    logic [1:0]        data_sram_size;
    logic [3:0]        data_sram_wstrb;
    logic [ADDR_W-1:0] data_sram_addr;
    logic [31:0]       data_sram_wdata;
    logic              data_sram_addr_ok, data_sram_data_ok;
    logic [31:0]       data_sram_rdata;
    logic [ADDR_W-1:0] araddr, awaddr;
    logic [2:0]        arsize, awsize;
    logic              arvalid, arready, rvalid, rready;
    logic [31:0]       rdata, wdata;
    logic              awvalid, awready, wvalid, wready, bvalid, bready;
    logic [3:0]        wstrb;

    int checks = 0;
    int errors = 0;

    sram_axi_bridge #(.ADDR_W(ADDR_W)) dut (
        .clk(clk), .reset(reset),
        .inst_sram_req(inst_sram_req), .inst_sram_addr(inst_sram_addr),
        .inst_sram_addr_ok(inst_sram_addr_ok), .inst_sram_data_ok(inst_sram_data_ok),
        .inst_sram_rdata(inst_sram_rdata),
        .data_sram_req(data_sram_req), .data_sram_wr(data_sram_wr),
        .data_sram_size(data_sram_size), .data_sram_wstrb(data_sram_wstrb),
        .data_sram_addr(data_sram_addr), .data_sram_wdata(data_sram_wdata),
        .data_sram_addr_ok(data_sram_addr_ok), .data_sram_data_ok(data_sram_data_ok),
        .data_sram_rdata(data_sram_rdata),
        .araddr(araddr), .arsize(arsize), .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rvalid(rvalid), .rready(rready),
        .awaddr(awaddr), .awsize(awsize), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
        .bvalid(bvalid), .bready(bready)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic idle_inputs();
        inst_sram_req = 0; inst_sram_addr = '0;
        data_sram_req = 0; data_sram_wr = 0; data_sram_size = 0;
        data_sram_wstrb = 0; data_sram_addr = '0; data_sram_wdata = '0;
        arready = 0; rvalid = 0; rdata = '0; awready = 0; wready = 0; bvalid = 0;
    endtask

    task automatic test_reset();
        reset = 1; idle_inputs();
        repeat (3) tick();
        reset = 0;
        settle();
        checks++; if (arvalid !== 1'b0 || rready !== 1'b0) begin errors++; $display("FAIL reset_rd arvalid=%b rready=%b want 0 0", arvalid, rready); end
        checks++; if (awvalid !== 1'b0 || wvalid !== 1'b0 || bready !== 1'b0) begin errors++; $display("FAIL reset_wr aw=%b w=%b b=%b want 0 0 0", awvalid, wvalid, bready); end
        checks++; if (inst_sram_data_ok !== 1'b0 || data_sram_data_ok !== 1'b0 || inst_sram_addr_ok !== 1'b0 || data_sram_addr_ok !== 1'b0) begin errors++; $display("FAIL reset_ok flags nonzero"); end
        checks++; if (araddr !== '0 || arsize !== 3'b000 || wdata !== '0 || wstrb !== 4'h0) begin errors++; $display("FAIL reset_latch araddr=%h arsize=%b wdata=%h wstrb=%h want 0", araddr, arsize, wdata, wstrb); end
    endtask

    task automatic test_inst_read();
        tick();
        inst_sram_req = 1; inst_sram_addr = 32'hbfc00000; arready = 1;
        settle();
        checks++; if (inst_sram_addr_ok !== 1'b1 || data_sram_addr_ok !== 1'b0) begin errors++; $display("FAIL ird_addr_ok got %b want 1", inst_sram_addr_ok); end
        tick();
        inst_sram_req = 0;
        settle();
        checks++; if (arvalid !== 1'b1 || araddr !== 32'hbfc00000 || arsize !== 3'b010) begin errors++; $display("FAIL ird_ar arvalid=%b araddr=%h arsize=%b want 1 bfc00000 010", arvalid, araddr, arsize); end
        tick();
        arready = 0; rvalid = 1; rdata = 32'h3c08bfc0;
        settle();
        checks++; if (inst_sram_data_ok !== 1'b1 || inst_sram_rdata !== 32'h3c08bfc0 || data_sram_data_ok !== 1'b0) begin errors++; $display("FAIL ird_data ok=%b rdata=%h want 1 3c08bfc0", inst_sram_data_ok, inst_sram_rdata); end
        tick();
        rvalid = 0; rdata = 32'h12345678;
        settle();
        checks++; if (inst_sram_data_ok !== 1'b0 || inst_sram_rdata !== 32'h3c08bfc0 || rready !== 1'b0) begin errors++; $display("FAIL ird_after ok=%b rdata=%h rready=%b want 0 3c08bfc0 0", inst_sram_data_ok, inst_sram_rdata, rready); end
        idle_inputs();
    endtask

    task automatic test_priority();
        tick();
        data_sram_req = 1; data_sram_wr = 0; data_sram_size = 2; data_sram_addr = 32'h100;
        inst_sram_req = 1; inst_sram_addr = 32'h200;
        settle();
        checks++; if (data_sram_addr_ok !== 1'b1 || inst_sram_addr_ok !== 1'b0) begin errors++; $display("FAIL prio_grant d=%b i=%b want 1 0", data_sram_addr_ok, inst_sram_addr_ok); end
        tick();
        data_sram_req = 0; arready = 1;
        settle();
        checks++; if (araddr !== 32'h100 || arvalid !== 1'b1 || inst_sram_addr_ok !== 1'b0) begin errors++; $display("FAIL prio_ar araddr=%h arvalid=%b iok=%b want 100 1 0", araddr, arvalid, inst_sram_addr_ok); end
        tick();
        arready = 0; rvalid = 1; rdata = 32'hcafef00d;
        settle();
        checks++; if (data_sram_data_ok !== 1'b1 || data_sram_rdata !== 32'hcafef00d || inst_sram_data_ok !== 1'b0 || inst_sram_addr_ok !== 1'b0) begin errors++; $display("FAIL prio_ddata ok=%b rdata=%h want 1 cafef00d", data_sram_data_ok, data_sram_rdata); end
        tick();
        rvalid = 0;
        settle();
        checks++; if (inst_sram_addr_ok !== 1'b1) begin errors++; $display("FAIL prio_inst_grant got %b want 1", inst_sram_addr_ok); end
        tick();
        inst_sram_req = 0; arready = 1;
        settle();
        checks++; if (araddr !== 32'h200 || arvalid !== 1'b1) begin errors++; $display("FAIL prio_inst_ar araddr=%h want 200", araddr); end
        tick();
        arready = 0; rvalid = 1; rdata = 32'h00c0ffee;
        settle();
        checks++; if (inst_sram_data_ok !== 1'b1 || inst_sram_rdata !== 32'h00c0ffee || data_sram_data_ok !== 1'b0 || data_sram_rdata !== 32'hcafef00d) begin errors++; $display("FAIL prio_idata iok=%b irdata=%h drdata=%h", inst_sram_data_ok, inst_sram_rdata, data_sram_rdata); end
        tick();
        idle_inputs();
    endtask

    task automatic test_byte_write();
        tick();
        data_sram_req = 1; data_sram_wr = 1; data_sram_size = 0; data_sram_wstrb = 4'b0010;
        data_sram_addr = 32'h1fc0; data_sram_wdata = 32'h0000ab00;
        settle();
        checks++; if (data_sram_addr_ok !== 1'b1) begin errors++; $display("FAIL bw_accept got %b want 1", data_sram_addr_ok); end
        tick();
        data_sram_req = 0; data_sram_wdata = 32'hffffffff; awready = 1;
        settle();
        checks++; if (awvalid !== 1'b1 || wvalid !== 1'b1 || awsize !== 3'b000 || awaddr !== 32'h1fc0 || wstrb !== 4'b0010 || wdata !== 32'h0000ab00 || bready !== 1'b0) begin errors++; $display("FAIL bw_aw aw=%b w=%b awsize=%b awaddr=%h wstrb=%b wdata=%h", awvalid, wvalid, awsize, awaddr, wstrb, wdata); end
        for (int c = 0; c < 2; c++) begin
            tick();
            awready = 0;
            settle();
            checks++; if (awvalid !== 1'b0 || wvalid !== 1'b1 || bready !== 1'b0) begin errors++; $display("FAIL bw_wait%0d aw=%b w=%b b=%b want 0 1 0", c, awvalid, wvalid, bready); end
        end
        tick();
        wready = 1;
        settle();
        checks++; if (wvalid !== 1'b1 || wdata !== 32'h0000ab00 || bready !== 1'b0) begin errors++; $display("FAIL bw_w w=%b wdata=%h b=%b", wvalid, wdata, bready); end
        tick();
        wready = 0;
        settle();
        checks++; if (wvalid !== 1'b0 || bready !== 1'b1 || data_sram_data_ok !== 1'b0) begin errors++; $display("FAIL bw_resp_wait w=%b b=%b ok=%b want 0 1 0", wvalid, bready, data_sram_data_ok); end
        tick();
        bvalid = 1;
        settle();
        checks++; if (data_sram_data_ok !== 1'b1 || inst_sram_data_ok !== 1'b0) begin errors++; $display("FAIL bw_done dok=%b iok=%b want 1 0", data_sram_data_ok, inst_sram_data_ok); end
        tick();
        bvalid = 0;
        settle();
        checks++; if (bready !== 1'b0 || data_sram_data_ok !== 1'b0) begin errors++; $display("FAIL bw_after b=%b ok=%b want 0 0", bready, data_sram_data_ok); end
        idle_inputs();
    endtask

    task automatic test_arready_stall();
        tick();
        inst_sram_req = 1; inst_sram_addr = 32'h80;
        settle();
        checks++; if (inst_sram_addr_ok !== 1'b1) begin errors++; $display("FAIL st_accept got %b want 1", inst_sram_addr_ok); end
        for (int c = 0; c < 5; c++) begin
            tick();
            inst_sram_addr = 32'h400 + 32'(c * 4); data_sram_req = 1; data_sram_addr = 32'h900;
            settle();
            checks++; if (arvalid !== 1'b1 || araddr !== 32'h80 || inst_sram_addr_ok !== 1'b0 || data_sram_addr_ok !== 1'b0) begin errors++; $display("FAIL st_hold%0d arvalid=%b araddr=%h iok=%b dok=%b", c, arvalid, araddr, inst_sram_addr_ok, data_sram_addr_ok); end
        end
        tick();
        inst_sram_req = 0; data_sram_req = 0; arready = 1;
        settle();
        checks++; if (arvalid !== 1'b1 || araddr !== 32'h80) begin errors++; $display("FAIL st_release araddr=%h want 80", araddr); end
        tick();
        arready = 0; rvalid = 1; rdata = 32'h5a5a0001;
        settle();
        checks++; if (inst_sram_data_ok !== 1'b1 || inst_sram_rdata !== 32'h5a5a0001) begin errors++; $display("FAIL st_data ok=%b rdata=%h", inst_sram_data_ok, inst_sram_rdata); end
        tick();
        idle_inputs();
    endtask

    task automatic test_reset_mid();
        tick();
        inst_sram_req = 1; inst_sram_addr = 32'h40;
        settle();
        checks++; if (inst_sram_addr_ok !== 1'b1) begin errors++; $display("FAIL rm_accept got %b want 1", inst_sram_addr_ok); end
        tick();
        inst_sram_req = 0; arready = 1;
        settle();
        tick();
        arready = 0; reset = 1; rvalid = 1; rdata = 32'hdeadbeef;
        settle();
        checks++; if (inst_sram_data_ok !== 1'b0 || data_sram_data_ok !== 1'b0) begin errors++; $display("FAIL rm_in_reset ok=%b want 0", inst_sram_data_ok); end
        tick();
        reset = 0;
        settle();
        checks++; if (rready !== 1'b0 || arvalid !== 1'b0 || inst_sram_data_ok !== 1'b0) begin errors++; $display("FAIL rm_after rready=%b arvalid=%b ok=%b want 0 0 0", rready, arvalid, inst_sram_data_ok); end
        tick();
        rvalid = 0;
        settle();
        checks++; if (inst_sram_data_ok !== 1'b0 || data_sram_data_ok !== 1'b0) begin errors++; $display("FAIL rm_later ok=%b want 0", inst_sram_data_ok); end
        idle_inputs();
    endtask

    task automatic test_random();
        logic [31:0] ref_mem [16];
        logic [31:0] slv_mem [16];
        bit i_pend = 0, d_pend = 0;
        bit o_vld = 0, o_data = 0, o_wr = 0;
        logic [31:0] o_addr = '0, o_wdata = '0;
        logic [3:0]  o_wstrb = '0;
        logic [1:0]  o_size = '0;
        bit s_rd = 0, s_aw = 0, s_w = 0, s_applied = 0;
        int s_rd_dly = 0, s_b_dly = 0, o_age = 0, done_cnt = 0;
        logic [3:0] s_rd_idx = '0, s_aw_idx = '0;
        logic [31:0] s_wdata = '0;
        logic [3:0]  s_wstrb = '0;
        for (int i = 0; i < 16; i++) begin
            ref_mem[i] = 32'ha5a50000 ^ (32'(i) * 32'h01010101);
            slv_mem[i] = ref_mem[i];
        end
        for (int cyc = 0; cyc < 4000; cyc++) begin
            tick();
            if (!i_pend && $urandom_range(0, 2) == 0) begin
                i_pend = 1;
                inst_sram_addr = 32'h1000 + 32'($urandom_range(0, 15) * 4);
            end
            if (!d_pend && $urandom_range(0, 2) == 0) begin
                int off, sz;
                d_pend = 1;
                sz = $urandom_range(0, 2);
                off = (sz == 0) ? $urandom_range(0, 3) : (sz == 1) ? 2 * $urandom_range(0, 1) : 0;
                data_sram_size  = 2'(sz);
                data_sram_wstrb = (sz == 0) ? 4'(1 << off) : (sz == 1) ? 4'(3 << off) : 4'hf;
                data_sram_addr  = 32'h1000 + 32'($urandom_range(0, 15) * 4 + off);
                data_sram_wr    = 1'($urandom_range(0, 1));
                data_sram_wdata = $urandom;
            end
            inst_sram_req = i_pend;
            data_sram_req = d_pend;
            arready = 1'($urandom_range(0, 1));
            awready = 1'($urandom_range(0, 1));
            wready  = 1'($urandom_range(0, 1));
            rvalid  = s_rd && (s_rd_dly == 0);
            rdata   = rvalid ? slv_mem[s_rd_idx] : $urandom;
            bvalid  = s_applied && (s_b_dly == 0);
            settle();

            if (inst_sram_addr_ok && data_sram_req) begin
                checks++; errors++; $display("FAIL rnd_prio inst granted while data_req=1");
            end
            if (inst_sram_addr_ok || data_sram_addr_ok) begin
                checks++; if (o_vld) begin errors++; $display("FAIL rnd_outstanding accept while busy"); end
                o_vld = 1; o_age = 0; o_data = data_sram_addr_ok;
                if (data_sram_addr_ok) begin
                    o_wr = data_sram_wr; o_addr = data_sram_addr; o_size = data_sram_size;
                    o_wstrb = data_sram_wstrb; o_wdata = data_sram_wdata; d_pend = 0;
                end else begin
                    o_wr = 0; o_addr = inst_sram_addr; o_size = 2; i_pend = 0;
                end
            end
            if (rvalid && rready) s_rd = 0;
            else if (s_rd && s_rd_dly > 0) s_rd_dly--;
            if (arvalid && arready) begin
                checks++; if (araddr !== o_addr || arsize !== {1'b0, o_size} || o_wr) begin errors++; $display("FAIL rnd_ar araddr=%h arsize=%b want %h %b", araddr, arsize, o_addr, {1'b0, o_size}); end
                s_rd = 1; s_rd_idx = araddr[5:2]; s_rd_dly = $urandom_range(0, 3);
            end
            if (bvalid && bready) begin s_aw = 0; s_w = 0; s_applied = 0; end
            else if (s_applied && s_b_dly > 0) s_b_dly--;
            if (awvalid && awready) begin
                checks++; if (awaddr !== o_addr || awsize !== {1'b0, o_size} || !o_wr) begin errors++; $display("FAIL rnd_aw awaddr=%h awsize=%b want %h %b", awaddr, awsize, o_addr, {1'b0, o_size}); end
                s_aw = 1; s_aw_idx = awaddr[5:2];
            end
            if (wvalid && wready) begin
                checks++; if (wstrb !== o_wstrb || wdata !== o_wdata) begin errors++; $display("FAIL rnd_w wstrb=%b wdata=%h want %b %h", wstrb, wdata, o_wstrb, o_wdata); end
                s_w = 1; s_wdata = wdata; s_wstrb = wstrb;
            end
            if (s_aw && s_w && !s_applied) begin
                for (int b = 0; b < 4; b++) if (s_wstrb[b]) slv_mem[s_aw_idx][8*b +: 8] = s_wdata[8*b +: 8];
                s_applied = 1; s_b_dly = $urandom_range(0, 3);
            end

            if (inst_sram_data_ok) begin
                checks++; if (!o_vld || o_data || inst_sram_rdata !== ref_mem[o_addr[5:2]]) begin errors++; $display("FAIL rnd_iread rdata=%h want %h", inst_sram_rdata, ref_mem[o_addr[5:2]]); end
                o_vld = 0; done_cnt++;
            end
            if (data_sram_data_ok) begin
                checks++;
                if (!o_vld || !o_data || inst_sram_data_ok) begin
                    errors++; $display("FAIL rnd_dok unexpected data_ok owner");
                end else if (o_wr) begin
                    for (int b = 0; b < 4; b++) if (o_wstrb[b]) ref_mem[o_addr[5:2]][8*b +: 8] = o_wdata[8*b +: 8];
                    if (slv_mem[o_addr[5:2]] !== ref_mem[o_addr[5:2]]) begin errors++; $display("FAIL rnd_write mem=%h want %h", slv_mem[o_addr[5:2]], ref_mem[o_addr[5:2]]); end
                end else if (data_sram_rdata !== ref_mem[o_addr[5:2]]) begin
                    errors++; $display("FAIL rnd_dread rdata=%h want %h", data_sram_rdata, ref_mem[o_addr[5:2]]);
                end
                o_vld = 0; done_cnt++;
            end
            if (o_vld) begin
                o_age++;
                if (o_age > 60) begin
                    checks++; errors++; $display("FAIL rnd_timeout no data_ok within 60 cycles");
                    break;
                end
            end
        end
        checks++; if (done_cnt < 100) begin errors++; $display("FAIL rnd_progress completed=%0d want >=100", done_cnt); end
        tick();
        idle_inputs();
        reset = 1;
        tick();
        reset = 0;
    endtask

    initial begin
        test_reset();
        test_inst_read();
        test_priority();
        test_byte_write();
        test_arready_stall();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/sram_axi_bridge.md
Name: sram_axi_bridge

Overview:
- Shares one AXI master port between the IF-stage inst SRAM-like port (read-only) and the MEM-stage data SRAM-like port.
- Fixed data-over-inst priority; one outstanding transaction at a time; sits between mycpu core and the AXI interconnect.
- AXI len=0, burst=INCR, id=0, lock/cache/prot are tied off at the top level.

Parameters:
- ADDR_W, 32, address width of both SRAM-like ports and the AXI port.

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
inst_sram_req  in  1  inst read request
inst_sram_addr  in  ADDR_W  inst word address; size is fixed at 2'h2
inst_sram_addr_ok  out  1  inst request accepted this cycle
inst_sram_data_ok  out  1  inst read data valid, 1-cycle pulse
inst_sram_rdata  out  32  inst read data
data_sram_req  in  1  data request
data_sram_wr  in  1  1=write, 0=read
data_sram_size  in  2  0=byte, 1=half, 2=word
data_sram_wstrb  in  4  write byte enables
data_sram_addr  in  ADDR_W  data address
data_sram_wdata  in  32  write data
data_sram_addr_ok  out  1  data request accepted this cycle
data_sram_data_ok  out  1  read data valid or write complete, 1-cycle pulse
data_sram_rdata  out  32  data read data
araddr  out  ADDR_W  AXI read address
arsize  out  3  {1'b0,size}
arvalid  out  1  read address valid
arready  in  1  read address ready
rdata  in  32  AXI read data
rvalid  in  1  read data valid
rready  out  1  read data ready
awaddr  out  ADDR_W  AXI write address
awsize  out  3  {1'b0,size}
awvalid  out  1  write address valid
awready  in  1  write address ready
wdata  out  32  write data
wstrb  out  4  write strobes
wvalid  out  1  write data valid
wready  in  1  write data ready
bvalid  in  1  write response valid
bready  out  1  write response ready

Behaviour:
- States: IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP. Reset -> IDLE. All valid/ready, addr_ok and data_ok outputs are 0; latched addr/size/wstrb/wdata/owner are 0.
- IDLE: addr_ok is combinational and high only in IDLE.
  - data_sram_req=1 -> data_sram_addr_ok=1, inst_sram_addr_ok=0, even if inst_sram_req=1.
  - Otherwise inst_sram_req=1 -> inst_sram_addr_ok=1.
  - On accept, latch addr, size (inst: 2), wstrb, wdata and owner. Next state is WR_REQ if a data write, else RD_ADDR.
- Outside IDLE, both addr_ok are 0 and pending requests wait.
- RD_ADDR: arvalid=1 with the latched araddr/arsize, held stable until arready. On arready -> RD_DATA.
- RD_DATA: rready=1. When rvalid=1, that same cycle the owner's data_ok=1 and its rdata=rdata (combinational passthrough), then -> IDLE.
- WR_REQ: awvalid and wvalid are asserted together. Each drops independently after its own handshake (aw_done, w_done flags).
  - When both are done, including when both handshake in the same cycle -> WR_RESP.
- WR_RESP: bready=1. On bvalid, data_sram_data_ok=1 that cycle, then -> IDLE. bresp and rresp are ignored.
- The non-owner's data_ok is always 0. Inactive rdata outputs hold the last value returned.
- Minimum latency with slave ready every cycle:
  - read: accept cycle N, arvalid N+1, data_ok N+2.
  - write: accept N, aw/w N+1, data_ok N+2.
  - A new request can be accepted the cycle after data_ok (back in IDLE).
- Reset asserted mid-transaction -> IDLE at the next edge with all valids low. The abandoned AXI transfer is not completed; the slave is reset together with the bridge.
- Inputs while a handshake is pending never alter the latched araddr/awaddr/wdata (AXI stability).

Test Plan:
- inst_sram_req at 0xbfc00000, arready=1, rvalid with 0x3c08bfc0 one cycle later -> addr_ok at N, arvalid at N+1, inst_sram_data_ok with rdata=0x3c08bfc0 at N+2.
- inst and data read requests in the same cycle -> data_sram_addr_ok=1, inst_sram_addr_ok=0. The inst request is granted on the first IDLE cycle after data_sram_data_ok.
- Data byte write, size=0, wstrb=4'b0010, addr 0x1fc0: awready 3 cycles before wready -> awvalid drops after its handshake, wvalid held, awsize=3'b000, bready only after both, data_ok on bvalid.
- arready held low 5 cycles -> arvalid and araddr stable throughout, no addr_ok to either port.
- Reset pulsed while in RD_DATA -> next cycle IDLE, rready=0, no data_ok pulse ever emitted for the aborted read.
